stream_encoder: RTL and testbench

Table-driven variable-length encoder, the transmit-side counterpart of the stream decoder. It accepts fixed-width symbols, looks up a programmable code and code width per symbol, and packs codes contiguously into WIDTH_OUT-bit words. Words leave through a show-ahead output buffer with ready/pop handshake. Its bitstream, after table programming with the inverse mapping, feeds the stream decoder's d/push input unchanged.

---
 rtl/stream_encoder_pkg.sv | 25 ++
 rtl/stream_encoder_fifo.sv | 53 +++++
 rtl/stream_encoder.sv | 186 ++++++++++++++++++
 tb/tb_stream_encoder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_encoder_pkg.sv
// Shared definitions for the stream encoder: default widths, FSM state encoding
// and a ceiling-log2 helper used to size counters and width fields.
package stream_encoder_pkg;

    localparam int DEF_WIDTH_SYM       = 8;
    localparam int DEF_WIDTH_OUT       = 64;
    localparam int DEF_MAX_CODE_LENGTH = 9;
    localparam int DEF_FIFO_DEPTH      = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_EMIT  = 2'd2
    } enc_state_e;

    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_encoder_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; head word is visible on
// rd_data_o whenever empty_o is low and reads as zero while empty.
module stream_encoder_fifo
    import stream_encoder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH_OUT,
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_W = log2_ceil(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = log2_ceil(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             wr_ok;
    logic             rd_ok;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign wr_ok     = wr_en_i && !full_o;
    assign rd_ok     = rd_en_i && !empty_o;
    assign count_o   = count_q;
    assign rd_data_o = empty_o ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
        end
    end

endmodule

// File: rtl/stream_encoder.sv
// Table-driven variable-length encoder packing codes MSB-first into output words.
// Define STREAM_ENCODER_BIT_COUNT_EN to add the total_bits code-bit counter output.
module stream_encoder
    import stream_encoder_pkg::*;
#(
    parameter int WIDTH_SYM            = DEF_WIDTH_SYM,
    parameter int WIDTH_OUT            = DEF_WIDTH_OUT,
    parameter int MAX_CODE_LENGTH      = DEF_MAX_CODE_LENGTH,
    parameter int LOG2_MAX_CODE_LENGTH = log2_ceil(MAX_CODE_LENGTH + 1),
    parameter int FIFO_DEPTH           = DEF_FIFO_DEPTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic [WIDTH_SYM-1:0]            d,
    output logic                            full,
    output logic [WIDTH_OUT-1:0]            q,
    output logic                            ready,
    input  logic                            pop,
    input  logic                            flush,
    input  logic                            table_push,
    input  logic [WIDTH_SYM-1:0]            table_addr,
    input  logic [LOG2_MAX_CODE_LENGTH-1:0] table_code_width,
    input  logic [MAX_CODE_LENGTH-1:0]      table_code
`ifdef STREAM_ENCODER_BIT_COUNT_EN
    ,
    output logic [31:0]                     total_bits
`endif
);

    localparam int LW     = LOG2_MAX_CODE_LENGTH;
    localparam int ACC_W  = 2 * WIDTH_OUT;
    localparam int FILL_W = log2_ceil(ACC_W + 1);
    localparam int CNT_W  = log2_ceil(FIFO_DEPTH + 1);
    localparam logic [FILL_W-1:0] WORD_FILL = FILL_W'(WIDTH_OUT);
    localparam logic [FILL_W-1:0] ACC_FILL  = FILL_W'(ACC_W);

    function automatic logic [LW-1:0] clamp_width(input logic [LW-1:0] w);
        if (w > LW'(MAX_CODE_LENGTH)) return LW'(MAX_CODE_LENGTH);
        return w;
    endfunction

    logic                   tbl_we_q;
    logic [WIDTH_SYM-1:0]   tbl_addr_q;
    logic [LW-1:0]          tbl_width_q;
    logic [MAX_CODE_LENGTH-1:0] tbl_code_q;
    logic [MAX_CODE_LENGTH-1:0] code_mem  [2**WIDTH_SYM];
    logic [LW-1:0]              width_mem [2**WIDTH_SYM];

    logic                   accept;
    logic                   vld_p1_q;
    logic                   vld_p2_q;
    logic [WIDTH_SYM-1:0]   sym_p1_q;
    logic [MAX_CODE_LENGTH-1:0] code_p2_q;
    logic [LW-1:0]          width_p2_q;

    logic [ACC_W-1:0]       acc_q, acc_d, acc_s, code_al;
    logic [FILL_W-1:0]      fill_q, fill_d, fill_s;
    logic                   extract;
    logic                   emit_pad;

    enc_state_e             state_q;
    logic [1:0]             drain_cnt_q;

    logic                   fifo_wr;
    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_empty;
    logic                   fifo_full;

    assign accept = push && !full;
    assign full   = (fifo_count >= CNT_W'(FIFO_DEPTH - 1)) || (state_q != ST_RUN);
    assign ready  = !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) tbl_we_q <= 1'b0;
        else     tbl_we_q <= table_push;
        tbl_addr_q  <= table_addr;
        tbl_width_q <= table_code_width;
        tbl_code_q  <= table_code;
    end

    // p1 -> p2: table read, old data on read-during-write
    always_ff @(posedge clk) begin
        if (tbl_we_q) begin
            code_mem[tbl_addr_q]  <= tbl_code_q;
            width_mem[tbl_addr_q] <= tbl_width_q;
        end
        code_p2_q  <= code_mem[sym_p1_q];
        width_p2_q <= clamp_width(width_mem[sym_p1_q]);
    end

    // p0 -> p1: symbol capture
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            vld_p1_q <= accept;
            vld_p2_q <= vld_p1_q;
        end
        sym_p1_q <= d;
    end

    // p2 -> accumulator: drop a completed word, then append the new code below the fill
    always_comb begin
        extract  = (fill_q >= WORD_FILL) && !fifo_full;
        acc_s    = extract ? (acc_q << WIDTH_OUT) : acc_q;
        fill_s   = extract ? (fill_q - WORD_FILL) : fill_q;
        code_al  = ACC_W'(code_p2_q) << (ACC_FILL - FILL_W'(width_p2_q));
        acc_d    = acc_s;
        fill_d   = fill_s;
        if (vld_p2_q) begin
            acc_d  = acc_s | (code_al >> fill_s);
            fill_d = fill_s + FILL_W'(width_p2_q);
        end
        emit_pad = (state_q == ST_EMIT) && (fill_q < WORD_FILL) && (fill_q != '0) && !fifo_full;
        if (emit_pad) begin
            acc_d  = '0;
            fill_d = '0;
        end
        fifo_wr = extract || emit_pad;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            fill_q <= '0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (flush) begin
                        state_q     <= ST_DRAIN;
                        drain_cnt_q <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_q == 2'd2) state_q <= (fill_d != '0) ? ST_EMIT : ST_RUN;
                    else                     drain_cnt_q <= drain_cnt_q + 2'd1;
                end
                ST_EMIT: begin
                    // a full word still pending leaves through the normal extract path first
                    if (emit_pad || (fill_q == '0)) state_q <= ST_RUN;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    stream_encoder_fifo #(
        .WIDTH (WIDTH_OUT),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (fifo_wr),
        .wr_data_i (acc_q[ACC_W-1 -: WIDTH_OUT]),
        .rd_en_i   (pop),
        .rd_data_o (q),
        .count_o   (fifo_count),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

`ifdef STREAM_ENCODER_BIT_COUNT_EN
    logic [31:0] total_bits_q;

    always_ff @(posedge clk) begin
        if (rst)           total_bits_q <= '0;
        else if (vld_p2_q) total_bits_q <= total_bits_q + 32'(width_p2_q);
    end

    assign total_bits = total_bits_q;
`endif

endmodule

// File: tb/tb_stream_encoder.sv
// Directed self-checking bench for stream_encoder: table-driven packing vectors
// plus hand-written sequences for latency, straddle, back-pressure and reset.
module tb_stream_encoder;

    logic        clk = 1'b0;
    logic        rst, push, pop, flush, table_push;
    logic [7:0]  d, table_addr;
    logic [3:0]  table_code_width;
    logic [8:0]  table_code;
    logic        full, ready;
    logic [63:0] q;
`ifdef STREAM_ENCODER_BIT_COUNT_EN
    logic [31:0] total_bits;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0]  n;
        logic [31:0] syms;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    stream_encoder dut (
        .clk              (clk),
        .rst              (rst),
        .push             (push),
        .d                (d),
        .full             (full),
        .q                (q),
        .ready            (ready),
        .pop              (pop),
        .flush            (flush),
        .table_push       (table_push),
        .table_addr       (table_addr),
        .table_code_width (table_code_width),
        .table_code       (table_code)
`ifdef STREAM_ENCODER_BIT_COUNT_EN
        ,
        .total_bits       (total_bits)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic prog(input logic [7:0] a, input logic [3:0] w, input logic [8:0] c);
        table_push       = 1'b1;
        table_addr       = a;
        table_code_width = w;
        table_code       = c;
        tick();
        table_push = 1'b0;
    endtask

    task automatic push_sym(input logic [7:0] s);
        d    = s;
        push = 1'b1;
        tick();
        push = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic pop_word();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int max);
        int n;
        n = 0;
        while (!ready && n < max) begin
            tick();
            n++;
        end
        chk({name, " ready"}, 64'(ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] syms;
        logic [63:0] expw;
        int          lat;
        int          acc_n;
        int          cyc;
        bit          seen;

        vecs[0] = '{8'd3, 32'h0201_0000, 64'hD000_0000_0000_0000};
        vecs[1] = '{8'd1, 32'h0000_0000, 64'h0000_0000_0000_0000};
        vecs[2] = '{8'd1, 32'h0100_0000, 64'h8000_0000_0000_0000};
        vecs[3] = '{8'd1, 32'h0300_0000, 64'hFF80_0000_0000_0000};
        vecs[4] = '{8'd2, 32'h0406_0000, 64'hAAD0_0000_0000_0000};
        vecs[5] = '{8'd3, 32'h0501_0500, 64'h8000_0000_0000_0000};
        vecs[6] = '{8'd1, 32'h0700_0000, 64'hFF80_0000_0000_0000};
        vecs[7] = '{8'd2, 32'h0602_0000, 64'hAC00_0000_0000_0000};
        vecs[8] = '{8'd2, 32'h0003_0000, 64'h7FC0_0000_0000_0000};

        rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; table_push = 1'b0;
        d = '0; table_addr = '0; table_code_width = '0; table_code = '0;
        tick();
        tick();
        chk("reset ready", 64'(ready), 64'd0);
        chk("reset full", 64'(full), 64'd0);
        chk("reset q", q, 64'd0);
        rst = 1'b0;
        tick();

        // Flush with nothing accumulated must not produce a word
        do_flush();
        repeat (10) tick();
        chk("empty flush ready", 64'(ready), 64'd0);
        chk("empty flush full", 64'(full), 64'd0);

        prog(8'h00, 4'd1,  9'h000);
        prog(8'h01, 4'd2,  9'h002);
        prog(8'h02, 4'd3,  9'h006);
        prog(8'h03, 4'd9,  9'h1FF);
        prog(8'h04, 4'd9,  9'h155);
        prog(8'h05, 4'd0,  9'h1FF);
        prog(8'h06, 4'd4,  9'h1FA);
        prog(8'h07, 4'd15, 9'h1FF);
        tick();

        for (int i = 0; i < 9; i++) begin
            syms = vecs[i].syms;
            for (int k = 0; k < int'(vecs[i].n); k++) push_sym(syms[31-8*k -: 8]);
            do_flush();
            lat = 1;
            while (!ready && lat < 20) begin
                tick();
                lat++;
            end
            chk($sformatf("vec%0d q", i), q, vecs[i].exp);
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'd5);
            pop_word();
            chk($sformatf("vec%0d single word", i), 64'(ready), 64'd0);
        end

        for (int s = 0; s < 256; s++) prog(8'(s), 4'd8, 9'(s));
        tick();
        for (int k = 1; k <= 8; k++) push_sym(8'(k));
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("w8 ready cycle %0d", c), 64'(ready), (c == 4) ? 64'd1 : 64'd0);
            if (c < 4) tick();
        end
        chk("w8 word", q, 64'h0102_0304_0506_0708);
        pop_word();

        // Nine-bit codes straddle the word boundary
        prog(8'hFF, 4'd9, 9'h1FF);
        tick();
        for (int k = 0; k < 8; k++) push_sym(8'hFF);
        wait_ready("straddle w0", 20);
        chk("straddle w0 q", q, 64'hFFFF_FFFF_FFFF_FFFF);
        pop_word();
        do_flush();
        wait_ready("straddle w1", 20);
        chk("straddle w1 q", q, 64'hFF00_0000_0000_0000);
        pop_word();
        chk("straddle drained", 64'(ready), 64'd0);

        // Back-pressure with pop held low
        acc_n = 0;
        cyc   = 0;
        seen  = 1'b0;
        while (!seen && cyc < 200) begin
            if (full) seen = 1'b1;
            else begin
                push_sym(8'(acc_n));
                acc_n++;
                cyc++;
            end
        end
        chk("bp full seen", 64'(seen), 64'd1);
        chk("bp accepted before full", 64'(acc_n), 64'd27);
        repeat (5) tick();
        chk("bp full held", 64'(full), 64'd1);
        for (int w = 0; w < 3; w++) begin
            expw = '0;
            for (int b = 0; b < 8; b++) expw = (expw << 8) | 64'(8 * w + b);
            wait_ready($sformatf("bp word%0d", w), 10);
            chk($sformatf("bp word%0d q", w), q, expw);
            pop_word();
        end
        chk("bp no extra word", 64'(ready), 64'd0);
        do_flush();
        wait_ready("bp tail", 20);
        chk("bp tail q", q, 64'h1819_1A00_0000_0000);
        pop_word();

        // Width-0 symbols add nothing
        prog(8'h05, 4'd0, 9'h1FF);
        tick();
        for (int k = 0; k < 100; k++) push_sym(8'h05);
        do_flush();
        repeat (20) tick();
        chk("w0 no word", 64'(ready), 64'd0);
        chk("w0 back to run", 64'(full), 64'd0);
        prog(8'h05, 4'd8, 9'h005);
        tick();

        // Reset with two words buffered and a partial word accumulated
        for (int k = 0; k < 18; k++) push_sym(8'(8'h20 + k));
        tick();
        tick();
        chk("pre-reset ready", 64'(ready), 64'd1);
        rst  = 1'b1;
        push = 1'b1;
        d    = 8'h40;
        tick();
        push = 1'b0;
        chk("mid reset ready", 64'(ready), 64'd0);
        chk("mid reset full", 64'(full), 64'd0);
        chk("mid reset q", q, 64'd0);
        rst = 1'b0;
        tick();
        for (int k = 1; k <= 8; k++) push_sym(8'(k));
        wait_ready("post reset", 10);
        chk("post reset word", q, 64'h0102_0304_0506_0708);
        pop_word();
        chk("post reset drained", 64'(ready), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
